// File: rtl/sram_word_controller.sv
// Single-word read/write engine between the bridge stream splitter and the
// board's asynchronous 16-bit SRAM. One request at a time; a write with a
// simultaneous read runs the write first and chains the read without an
// idle cycle. Every SRAM-facing output is registered.
module sram_word_controller #(
  parameter int ADDR_WIDTH = 17,
  parameter int READ_WAIT  = 3,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  word_rd,
  input  logic                  word_wr,
  input  logic [25:0]           word_addr,
  input  logic [15:0]           word_data,
  output logic [15:0]           word_q,
  output logic                  word_busy,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [15:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_i,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  localparam logic [2:0] RD_CNT = 3'(READ_WAIT - 1);
  localparam logic [2:0] WR_CNT = 3'(WRITE_WAIT - 1);

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic                  pend_rd, pend_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
  logic [15:0]           q_nxt, dq_o_nxt;
  logic [ADDR_WIDTH-1:0] a_nxt;
  logic                  dq_oe_nxt, oe_n_nxt, we_n_nxt, byte_n_nxt;

  // Byte 0 selects within the word; bits above the SRAM are dropped (wrap).
  logic [ADDR_WIDTH-1:0] req_addr;
  assign req_addr = word_addr[ADDR_WIDTH:1];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{word_addr[0], word_addr[25:ADDR_WIDTH+1]};

  // Busy is combinational so the requester sees it in the request cycle.
  assign word_busy = (state != IDLE) | word_rd | word_wr;

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend_rd;
    rd_addr_nxt = rd_addr;
    q_nxt       = word_q;
    a_nxt       = sram_a;
    dq_o_nxt    = sram_dq_o;
    dq_oe_nxt   = sram_dq_oe;
    oe_n_nxt    = sram_oe_n;
    we_n_nxt    = sram_we_n;
    byte_n_nxt  = sram_ub_n;
    case (state)
      IDLE: begin
        if (word_wr) begin
          a_nxt       = req_addr;
          dq_o_nxt    = word_data;
          dq_oe_nxt   = 1'b1;
          byte_n_nxt  = 1'b0;
          pend_nxt    = word_rd;
          rd_addr_nxt = req_addr;
          state_nxt   = WR_SETUP;
        end else if (word_rd) begin
          a_nxt      = req_addr;
          oe_n_nxt   = 1'b0;
          byte_n_nxt = 1'b0;
          dq_oe_nxt  = 1'b0;
          cnt_nxt    = RD_CNT;
          state_nxt  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          q_nxt      = sram_dq_i;
          oe_n_nxt   = 1'b1;
          byte_n_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WR_SETUP: begin
        we_n_nxt  = 1'b0;
        cnt_nxt   = WR_CNT;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          we_n_nxt  = 1'b1;
          state_nxt = WR_HOLD;
        end
      end
      WR_HOLD: begin
        dq_oe_nxt = 1'b0;
        if (pend_rd) begin
          // Chained read: strobes stay enabled, bus already released here.
          a_nxt     = rd_addr;
          oe_n_nxt  = 1'b0;
          cnt_nxt   = RD_CNT;
          pend_nxt  = 1'b0;
          state_nxt = RD_WAIT;
        end else begin
          byte_n_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered SRAM-side outputs; reset aborts any access.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      pend_rd    <= 1'b0;
      rd_addr    <= '0;
      word_q     <= 16'h0;
      sram_a     <= '0;
      sram_dq_o  <= 16'h0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend_rd    <= pend_nxt;
      rd_addr    <= rd_addr_nxt;
      word_q     <= q_nxt;
      sram_a     <= a_nxt;
      sram_dq_o  <= dq_o_nxt;
      sram_dq_oe <= dq_oe_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_ub_n  <= byte_n_nxt;
      sram_lb_n  <= byte_n_nxt;
    end
  end

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: asynchronous SRAM model on the pins, a
// word-array reference of expected memory contents, and cycle-exact strobe
// expectations derived from the request cycle.
module tb_sram_word_controller;
  localparam int AW = 17;
  localparam int RW = 3;
  localparam int WW = 2;

  logic          clk_sys = 1'b0;
  logic          reset, word_rd, word_wr;
  logic [25:0]   word_addr;
  logic [15:0]   word_data, word_q, sram_dq_o, sram_dq_i;
  logic          word_busy, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [AW-1:0] sram_a;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [15:0] ref_mem  [0:(1<<AW)-1];

  sram_word_controller #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk_sys(clk_sys), .reset(reset), .word_rd(word_rd), .word_wr(word_wr),
    .word_addr(word_addr), .word_data(word_data), .word_q(word_q),
    .word_busy(word_busy), .sram_a(sram_a), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n));

  always #5 clk_sys = ~clk_sys;

  // Asynchronous SRAM: read data visible while OE low, written while WE low.
  assign sram_dq_i = (!sram_oe_n && !sram_ub_n && !sram_lb_n) ? sram_mem[sram_a] : 16'hFFFF;
  always @(posedge clk_sys)
    if (!sram_we_n && sram_dq_oe && !sram_ub_n && !sram_lb_n) sram_mem[sram_a] <= sram_dq_o;

  // Bus contention watch: OE/WE overlap or driving the bus while OE is low.
  always @(negedge clk_sys)
    if (!reset && ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n))) viol++;

  function automatic int widx(input logic [25:0] a);
    return (int'(a) / 2) % (1 << AW);
  endfunction

  task automatic step();
    @(posedge clk_sys); #1;
    word_rd = 1'b0; word_wr = 1'b0;
    #1;
  endtask

  // Write transaction with per-cycle strobe/busy expectations.
  task automatic do_write(input logic [25:0] addr, input logic [15:0] data);
    logic eb, ewe, eoe;
    word_addr = addr; word_data = data; word_wr = 1'b1; word_rd = 1'b0; #1;
    for (int c = 0; c <= WW + 3; c++) begin
      if (c > 0) step();
      eb = (c <= WW + 2); ewe = !(c >= 2 && c <= WW + 1); eoe = (c >= 1 && c <= WW + 2);
      checks++;
      if (word_busy !== eb || sram_we_n !== ewe || sram_dq_oe !== eoe) begin
        failures++;
        $display("FAIL wr_timing addr=%h c=%0d busy=%b we_n=%b dq_oe=%b expected %b %b %b",
                 addr, c, word_busy, sram_we_n, sram_dq_oe, eb, ewe, eoe);
      end
      if (c == 1) begin
        checks++;
        if (sram_a !== AW'(widx(addr)) || sram_dq_o !== data) begin
          failures++;
          $display("FAIL wr_addr sram_a=%h dq_o=%h expected %h %h", sram_a, sram_dq_o, widx(addr), data);
        end
      end
    end
    ref_mem[widx(addr)] = data;
    checks++;
    if (sram_mem[widx(addr)] !== data) begin
      failures++;
      $display("FAIL wr_mem word=%h got=%h expected %h", widx(addr), sram_mem[widx(addr)], data);
    end
  endtask

  // Read transaction; word_q checked in the first not-busy cycle.
  task automatic do_read(input logic [25:0] addr);
    logic eb, eoe_n;
    logic [15:0] prev;
    prev = word_q;
    word_addr = addr; word_rd = 1'b1; word_wr = 1'b0; #1;
    for (int c = 0; c <= RW + 1; c++) begin
      if (c > 0) step();
      eb = (c <= RW); eoe_n = !(c >= 1 && c <= RW);
      checks++;
      if (word_busy !== eb || sram_oe_n !== eoe_n) begin
        failures++;
        $display("FAIL rd_timing addr=%h c=%0d busy=%b oe_n=%b expected %b %b",
                 addr, c, word_busy, sram_oe_n, eb, eoe_n);
      end
      if (c == RW) begin
        checks++;
        if (word_q !== prev) begin
          failures++;
          $display("FAIL rd_hold_q word_q=%h expected %h", word_q, prev);
        end
      end
    end
    checks++;
    if (word_q !== ref_mem[widx(addr)]) begin
      failures++;
      $display("FAIL rd_data addr=%h word_q=%h expected %h", addr, word_q, ref_mem[widx(addr)]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; word_rd = 0; word_wr = 0; word_addr = 0; word_data = 0;
    repeat (3) step();
    checks++;
    if ({word_q, sram_a, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, word_busy}
        !== {16'h0, 17'h0, 16'h0, 1'b0, 4'b1111, 1'b0}) begin
      failures++;
      $display("FAIL reset_state q=%h a=%h dq_o=%h oe=%b strobes=%b%b%b%b busy=%b expected zeros/ones",
               word_q, sram_a, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, word_busy);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    do_write(26'h000010, 16'h1234);
    do_read(26'h000010);
    repeat (10) step();
    checks++;
    if (word_q !== 16'h1234) begin
      failures++;
      $display("FAIL rd_persist word_q=%h expected 1234", word_q);
    end
  endtask

  task automatic test_back_to_back();
    do_write(26'h000100, 16'hAABB);
    do_write(26'h000102, 16'hCCDD);
    checks++;
    if (sram_mem[17'h80] !== 16'hAABB || sram_mem[17'h81] !== 16'hCCDD || viol != 0) begin
      failures++;
      $display("FAIL b2b mem80=%h mem81=%h viol=%0d expected aabb ccdd 0",
               sram_mem[17'h80], sram_mem[17'h81], viol);
    end
  endtask

  task automatic test_simultaneous();
    logic ok_busy, ok_oe;
    ok_busy = 1'b1; ok_oe = 1'b1;
    word_addr = 26'h000020; word_data = 16'h5A5A; word_rd = 1'b1; word_wr = 1'b1; #1;
    for (int c = 0; c <= WW + RW + 3; c++) begin
      if (c > 0) step();
      if (word_busy !== (c <= WW + RW + 2)) ok_busy = 1'b0;
      if (sram_oe_n !== !(c >= WW + 3 && c <= WW + RW + 2)) ok_oe = 1'b0;
    end
    ref_mem[widx(26'h000020)] = 16'h5A5A;
    checks++;
    if (!ok_busy || !ok_oe) begin
      failures++;
      $display("FAIL simul_timing busy_ok=%b oe_ok=%b expected 1 1", ok_busy, ok_oe);
    end
    checks++;
    if (word_q !== 16'h5A5A) begin
      failures++;
      $display("FAIL simul_data word_q=%h expected 5a5a", word_q);
    end
  endtask

  task automatic test_random();
    logic [25:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 26'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(a, 16'($urandom));
      else if ($urandom_range(0, 1) == 0) do_read(a);
      else do_read(26'(ref_idx_addr(i)));
      repeat ($urandom_range(0, 2)) step();
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL strobe_overlap count=%0d expected 0", viol);
    end
  endtask

  // Byte address of a recently used word so random reads hit written data.
  function automatic int ref_idx_addr(input int i);
    return (i % 2 == 0) ? 32'h10 : 32'h100;
  endfunction

  task automatic test_wrap_reset();
    do_write(26'h0040004, 16'hBEEF);
    checks++;
    if (sram_mem[17'h00002] !== 16'hBEEF) begin
      failures++;
      $display("FAIL wrap mem2=%h expected beef", sram_mem[17'h00002]);
    end
    word_addr = 26'h000200; word_data = 16'h7777; word_wr = 1'b1; #1;
    step(); step();
    checks++;
    if (sram_we_n !== 1'b0) begin
      failures++;
      $display("FAIL pulse_entry we_n=%b expected 0", sram_we_n);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({word_q, sram_a, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, word_busy}
        !== {16'h0, 17'h0, 16'h0, 1'b0, 4'b1111, 1'b0}) begin
      failures++;
      $display("FAIL reset_abort q=%h a=%h dq_o=%h oe=%b strobes=%b%b%b%b busy=%b expected reset values",
               word_q, sram_a, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, word_busy);
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || word_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset we_n=%b dq_oe=%b busy=%b expected 1 0 0", sram_we_n, sram_dq_oe, word_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = 16'h0;
      ref_mem[i]  = 16'h0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_simultaneous();
    test_random();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_word_controller.md
# sram_word_controller

Executes single 16-bit word read/write requests from the 32-bit bridge stream splitter against the board's asynchronous 16-bit SRAM. It sits directly downstream of that splitter and consumes its `word_rd`/`word_wr`/`word_addr`/`word_data` command port. It answers on the same port with `word_q` and `word_busy`, and drives the SRAM pins through a split (o/oe/i) data bus that the top level tristates.

## Interface
- `ADDR_WIDTH`, 17: SRAM word-address width; `sram_a = word_addr[ADDR_WIDTH:1]`.
- `READ_WAIT`, 3: cycles `sram_oe_n` is held low before sampling `sram_dq_i`; minimum 1.
- `WRITE_WAIT`, 2: cycles `sram_we_n` is held low; minimum 1.

Ports:
- `clk_sys` in 1: sole clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `word_rd` in 1: single-cycle read request.
- `word_wr` in 1: single-cycle write request.
- `word_addr` in 26: byte address; bit 0 and bits above `ADDR_WIDTH` are ignored.
- `word_data` in 16: write data, sampled with `word_wr`.
- `word_q` out 16: read data, held until the next read completes.
- `word_busy` out 1: request in progress; combinational.
- `sram_a` out `ADDR_WIDTH`: SRAM address.
- `sram_dq_o` out 16: SRAM write data.
- `sram_dq_oe` out 1: 1 = drive the SRAM data bus.
- `sram_dq_i` in 16: SRAM read data.
- `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM strobes, active low.

## Operation
- `word_busy = (state != IDLE) | word_rd | word_wr`. Busy therefore rises in the same cycle as the request, so the upstream sees busy on its very next check.
- States:
  - IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD.
  - 3-bit wait counter `cnt`.
  - Pending-read flag `pend_rd`, plus a latched read address.
- IDLE + `word_wr`:
  - Latch address and data into `sram_a` / `sram_dq_o`.
  - Set `sram_dq_oe` = 1, `ub_n` = `lb_n` = 0; go to WR_SETUP.
- IDLE + `word_rd` (no `word_wr`):
  - Latch address; set `oe_n` = 0, `ub_n` = `lb_n` = 0, `dq_oe` = 0.
  - Load `cnt` = `READ_WAIT` − 1; go to RD_WAIT.
- RD_WAIT:
  - Decrement `cnt` while it is nonzero.
  - At `cnt` == 0: `word_q <= sram_dq_i`, `oe_n` = 1, `ub_n` = `lb_n` = 1; go to IDLE.
- WR_SETUP (1 cycle): `we_n` = 0, `cnt` = `WRITE_WAIT` − 1; go to WR_PULSE.
- WR_PULSE: at `cnt` == 0, `we_n` = 1; go to WR_HOLD. Address and data stay driven.
- WR_HOLD (1 cycle): `dq_oe` = 0.
  - If `pend_rd` is set: start the latched read, exactly as from IDLE; clear `pend_rd`.
  - Otherwise: `ub_n` = `lb_n` = 1; go to IDLE.
- Simultaneous `word_rd` and `word_wr` in IDLE: the write executes first. `pend_rd` is set and the read address is latched from the same `word_addr`. Busy stays high continuously until the read completes.
- A request arriving while state != IDLE is a protocol violation. It is ignored, with no state change.
- Address wrap: bits above `ADDR_WIDTH` are dropped, so the address wraps modulo 2^`ADDR_WIDTH` words.
- `oe_n` and `we_n` are never low in the same cycle. `dq_oe` is never 1 while `oe_n` is 0.

## Timing
- Cycle 0 is the cycle in which the request is high. All outputs other than `word_busy` are registered.
- Read:
  - `oe_n` is low in cycles 1..`READ_WAIT`.
  - `word_q` updates at the edge ending cycle `READ_WAIT`.
  - Busy is high in cycles 0..`READ_WAIT` and low from cycle `READ_WAIT`+1.
  - Latency is `READ_WAIT`+1 cycles.
- Write:
  - Setup in cycle 1.
  - `we_n` is low in cycles 2..`WRITE_WAIT`+1.
  - Hold in cycle `WRITE_WAIT`+2.
  - Busy is low from cycle `WRITE_WAIT`+3.
- A back-to-back request may be issued in the first cycle in which busy is low.
- Reset values:
  - State IDLE, `pend_rd` = 0, `cnt` = 0.
  - `word_q` = 0, `sram_a` = 0, `sram_dq_o` = 0, `sram_dq_oe` = 0.
  - `oe_n` = `we_n` = `ub_n` = `lb_n` = 1.
  - `word_busy` = 0 when no request is present.
- Reset during an access: at the reset edge, `we_n` / `oe_n` go high and `dq_oe` goes to 0. The in-flight access and any pending read are discarded, and `word_q` is cleared.

## Test plan
All scenarios use `READ_WAIT` = 3, `WRITE_WAIT` = 2, with an SRAM behavioural model.

- Write: `word_addr` = 0x000010, `word_data` = 0x1234. Expect:
  - `sram_a` = 0x00008.
  - `we_n` low in cycles 2–3; `dq_oe` high in cycles 1–4.
  - Busy low at cycle 5; model holds 0x1234 at 0x00008.
- Read back: `word_addr` = 0x000010. Expect:
  - `oe_n` low in cycles 1–3.
  - `word_q` = 0x1234 in cycle 4; busy low in cycle 4.
  - `word_q` unchanged 10 cycles later.
- Upstream-style pair: 0x000100 / 0xAABB, then 0x000102 / 0xCCDD issued in the first not-busy cycle. Expect model words 0x80 = 0xAABB and 0x81 = 0xCCDD, with no strobe overlap.
- Simultaneous request: `word_rd` = `word_wr` = 1, addr 0x000020, data 0x5A5A. Expect:
  - Write completes, then the read starts with no IDLE gap.
  - Busy high continuously; `word_q` = 0x5A5A.
- Wrap and reset: write to `word_addr` = 0x0040004. Expect model word 0x00002 written. Then assert `reset` during WR_PULSE: `we_n` is high on the next edge and all outputs return to their reset values.
